// File: rtl/lscc_led_pkg.sv
// Shared constants and types for the LED fade engine.
//   NumLeds      : number of LED channels
//   LedLevelMax  : brightness level of a freshly lit LED
//   PwmSteps     : PWM steps per period (levels 0..15 map to 0..15 on-steps)
//   led_level_t  : 4-bit per-LED brightness level
package lscc_led_pkg;

    localparam int unsigned NumLeds  = 8;
    localparam int unsigned PwmSteps = 15;

    typedef logic [3:0] led_level_t;

    localparam led_level_t LedLevelMax = 4'd15;

endpackage : lscc_led_pkg

// File: rtl/lscc_tick_gen.sv
// Free-running divider producing a one-cycle tick every DIV clocks.
// Ports:
//   i_clk    : clock
//   i_rst    : asynchronous active-high reset
//   o_tick_c : combinational tick, high while the counter sits at DIV-1
module lscc_tick_gen
    import lscc_led_pkg::*;
#(
    parameter int unsigned DIV = 64
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_tick_c
);

    localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

    logic [CntW-1:0] r_cnt;
    logic            w_wrap;

    assign w_wrap = (r_cnt == CntMax);

    // Counter wraps at DIV-1; with DIV = 1 it stays at 0 and ticks every cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick_c = w_wrap;

endmodule : lscc_tick_gen

// File: rtl/led_fade.sv
// PWM fade engine: every lit LED jumps to full brightness and then decays one
// level per decay tick once released, giving the trailing glow of a KITT sweep.
// Ports:
//   clk_i         : clock, all state on the rising edge
//   rst_i         : asynchronous active-high reset
//   en_i          : engine enable; low forces all LEDs off and clears levels
//   led_pattern_i : per-LED lit pattern, polarity IN_POLARITY
//   led_o         : PWM-dimmed LED drive, polarity OUT_POLARITY
module led_fade
    import lscc_led_pkg::*;
#(
    parameter int unsigned CLK_IN_MHZ   = 125,
    parameter logic        IN_POLARITY  = 1'b0,
    parameter logic        OUT_POLARITY = 1'b0,
    parameter int unsigned PWM_DIV      = 64,
    parameter int unsigned DECAY_CYCLES = CLK_IN_MHZ * 1000 * 10
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic [NumLeds-1:0] led_pattern_i,
    output logic [NumLeds-1:0] led_o
);

    localparam int unsigned PwmCntW = $clog2(PwmSteps);
    localparam logic [PwmCntW-1:0] PwmCntMax = PwmCntW'(PwmSteps - 1);

    logic [NumLeds-1:0] r_pattern_q;
    logic [PwmCntW-1:0] r_pwm_cnt;
    logic [NumLeds-1:0] w_led;
    logic               w_pwm_tick;
    logic               w_decay_tick;

    lscc_tick_gen #(.DIV(PWM_DIV)) u_pwm_tick (
        .i_clk    (clk_i),
        .i_rst    (rst_i),
        .o_tick_c (w_pwm_tick)
    );

    lscc_tick_gen #(.DIV(DECAY_CYCLES)) u_decay_tick (
        .i_clk    (clk_i),
        .i_rst    (rst_i),
        .o_tick_c (w_decay_tick)
    );

    // Input pattern normalised so that 1 always means lit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pattern_q <= '0;
        end else begin
            r_pattern_q <= ~(led_pattern_i ^ {NumLeds{IN_POLARITY}});
        end
    end

    // PWM position 0..14; keeps running while disabled.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pwm_cnt <= '0;
        end else if (w_pwm_tick) begin
            if (r_pwm_cnt == PwmCntMax) begin
                r_pwm_cnt <= '0;
            end else begin
                r_pwm_cnt <= r_pwm_cnt + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < int'(NumLeds); g++) begin : g_led
        led_level_t r_level;
        logic       r_led_bit;
        logic       w_on;

        // Lit beats decay, so a re-lit LED never loses a step to a coinciding tick.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_level <= '0;
            end else if (!en_i) begin
                r_level <= '0;
            end else if (r_pattern_q[g]) begin
                r_level <= LedLevelMax;
            end else if (w_decay_tick && (r_level != '0)) begin
                r_level <= r_level - 1'b1;
            end
        end

        // Level L gives L on-steps out of 15: 15 is always on, 0 always off.
        assign w_on = en_i && (r_pwm_cnt < r_level);

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_led_bit <= ~OUT_POLARITY;
            end else begin
                r_led_bit <= w_on ? OUT_POLARITY : ~OUT_POLARITY;
            end
        end

        assign w_led[g] = r_led_bit;
    end

    assign led_o = w_led;

endmodule : led_fade

// File: tb/tb_led_fade.sv
// Self-checking bench for led_fade: table vectors, hand-written fade corner
// cases and a randomized phase against a cycle-count based reference model.
module tb_led_fade;
    import lscc_led_pkg::*;

    localparam int unsigned TB_PWM_DIV = 1;
    localparam int unsigned TB_DECAY   = 4;

    logic       clk = 1'b0;
    logic       rst, en, rst2, en2;
    logic [7:0] pat, pat2, led, led2;

    always #5 clk = ~clk;

    led_fade #(
        .CLK_IN_MHZ(125), .IN_POLARITY(1'b0), .OUT_POLARITY(1'b0),
        .PWM_DIV(TB_PWM_DIV), .DECAY_CYCLES(TB_DECAY)
    ) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .led_pattern_i(pat), .led_o(led)
    );

    led_fade #(
        .CLK_IN_MHZ(125), .IN_POLARITY(1'b1), .OUT_POLARITY(1'b1),
        .PWM_DIV(TB_PWM_DIV), .DECAY_CYCLES(TB_DECAY)
    ) dut_p (
        .clk_i(clk), .rst_i(rst2), .en_i(en2), .led_pattern_i(pat2), .led_o(led2)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: k = clock edges since reset release. Tick timing is
    // derived arithmetically from k rather than from counters.
    int         k;
    logic [7:0] m_pat;
    logic [7:0] m_led;
    int         m_lvl [8];

    typedef struct {
        logic       en;
        logic [7:0] pat;
        logic [7:0] exp_led;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        k     = 0;
        m_pat = 8'h00;
        m_led = 8'hFF;
        for (int i = 0; i < 8; i++) m_lvl[i] = 0;
    endtask

    // Apply inputs for one clock, advance the model, compare led_o after the edge.
    task automatic step(input logic e, input logic [7:0] p);
        bit         dtick;
        int         pw;
        int         nl [8];
        logic [7:0] nled;
        en    = e;
        pat   = p;
        dtick = (k % TB_DECAY) == (TB_DECAY - 1);
        pw    = (k / TB_PWM_DIV) % 15;
        for (int i = 0; i < 8; i++) begin
            nled[i] = (e && (pw < m_lvl[i])) ? 1'b0 : 1'b1;
            if (!e)                         nl[i] = 0;
            else if (m_pat[i])              nl[i] = 15;
            else if (dtick && m_lvl[i] > 0) nl[i] = m_lvl[i] - 1;
            else                            nl[i] = m_lvl[i];
        end
        m_pat = ~p;
        m_led = nled;
        for (int i = 0; i < 8; i++) m_lvl[i] = nl[i];
        k++;
        @(posedge clk);
        #1;
        check("model", led, m_led);
    endtask

    task automatic reset_mid();
        rst = 1'b1;
        #1;
        check("reset_async", led, 8'hFF);
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", led, 8'hFF);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int guard;
        rst = 1'b0; en = 1'b0; pat = 8'hFF;
        rst2 = 1'b0; en2 = 1'b0; pat2 = 8'h00;

        tbl[0] = '{1'b1, 8'hFF, 8'hFF};
        tbl[1] = '{1'b1, 8'hFF, 8'hFF};
        tbl[2] = '{1'b1, 8'hF7, 8'hFF};
        tbl[3] = '{1'b1, 8'hF7, 8'hFF};
        tbl[4] = '{1'b1, 8'hF7, 8'hF7};
        tbl[5] = '{1'b1, 8'hF7, 8'hF7};
        tbl[6] = '{1'b1, 8'hF7, 8'hF7};
        tbl[7] = '{1'b1, 8'hF7, 8'hF7};

        // Asynchronous reset before any clock edge.
        #1;
        rst  = 1'b1;
        rst2 = 1'b1;
        #1;
        check("reset_noclk", led, 8'hFF);
        check("reset_noclk_pol", led2, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        // Idle pattern stays dark, then a held lit bit 3 appears two edges later.
        foreach (tbl[i]) begin
            step(tbl[i].en, tbl[i].pat);
            check("table", led, tbl[i].exp_led);
        end
        repeat (10) step(1'b1, 8'hF7);
        check("lit_steady", led, 8'hF7);

        // Release: level 15 decays to 0 at one step per 4 clocks.
        repeat (70) step(1'b1, 8'hFF);
        check("decay_dark", led, 8'hFF);
        check("decay_level0", 8'(dut.g_led[3].r_level), 8'd0);

        // Re-light on the very edge where a decay tick meets level 7.
        repeat (3) step(1'b1, 8'hF7);
        guard = 0;
        while (!(m_lvl[3] == 7 && (k % TB_DECAY) == (TB_DECAY - 2)) && guard < 200) begin
            step(1'b1, 8'hFF);
            guard++;
        end
        check("relight_reach", 8'(guard < 200), 8'd1);
        check("relight_pre", 8'(dut.g_led[3].r_level), 8'd7);
        step(1'b1, 8'hF7);
        check("relight_hold7", 8'(dut.g_led[3].r_level), 8'd7);
        step(1'b1, 8'hFF);
        check("relight_wins", 8'(dut.g_led[3].r_level), 8'd15);

        // Drop enable mid-fade at level 10.
        guard = 0;
        while (m_lvl[3] != 10 && guard < 200) begin
            step(1'b1, 8'hFF);
            guard++;
        end
        check("en_reach", 8'(guard < 200), 8'd1);
        step(1'b0, 8'hFF);
        step(1'b0, 8'hFF);
        check("en_off_led", led, 8'hFF);
        check("en_off_level", 8'(dut.g_led[3].r_level), 8'd0);
        repeat (20) step(1'b1, 8'hFF);
        check("en_back_dark", led, 8'hFF);

        // Randomized traffic with occasional mid-fade resets.
        for (int n = 0; n < 300; n++) begin
            logic       re;
            logic [7:0] rp;
            re = ($urandom_range(0, 15) != 0);
            rp = 8'($urandom) | 8'($urandom);
            repeat ($urandom_range(1, 6)) step(re, rp);
            if ((n % 100) == 57) reset_mid();
        end

        // Inverted polarities on the second instance.
        en2  = 1'b1;
        pat2 = 8'h01;
        rst2 = 1'b0;
        repeat (3) @(posedge clk);
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            #1;
            check("pol_steady", led2, 8'h01);
        end
        rst2 = 1'b1;
        #1;
        check("pol_reset", led2, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_led_fade

// File: doc/led_fade.md
LED_FADE -- requirements
Module: led_fade

Interface
REQ-001 SHALL have parameter CLK_IN_MHZ, default 125: input clock frequency in MHz.
REQ-002 SHALL have parameter IN_POLARITY, default 1'b0: led_pattern_i bit value meaning "lit" (0 = active-low).
REQ-003 SHALL have parameter OUT_POLARITY, default 1'b0: led_o bit value meaning "LED on" (0 = active-low).
REQ-004 SHALL have parameter PWM_DIV, default 64: clocks per PWM step, minimum 1.
REQ-005 SHALL have parameter DECAY_CYCLES, default CLK_IN_MHZ*1000*10 (10 ms): clocks per brightness decay step, minimum 1.
REQ-006 clk_i  input  1  sole clock; all state on rising edge.
REQ-007 rst_i  input  1  reset; asynchronous, active-high.
REQ-008 en_i  input  1  fade engine enable; 0 forces all LEDs off and clears levels.
REQ-009 led_pattern_i  input  8  per-LED lit pattern from the KITT sweep stage, polarity IN_POLARITY.
REQ-010 led_o  output  8  PWM-dimmed LED drive, polarity OUT_POLARITY.

Function
REQ-011 SHALL register led_pattern_i every cycle into pattern_q, normalised so 1 = lit: pattern_q[i] = led_pattern_i[i] XNOR IN_POLARITY.
REQ-012 SHALL keep one 4-bit level[i] (0..15) per LED.
REQ-013 SHALL generate pwm_tick: 1-cycle pulse every PWM_DIV clocks from a free-running counter wrapping at PWM_DIV-1.
REQ-014 SHALL generate decay_tick: 1-cycle pulse every DECAY_CYCLES clocks from a free-running counter wrapping at DECAY_CYCLES-1.
REQ-015 SHALL keep pwm_cnt (0..14), advancing on pwm_tick and wrapping 14 -> 0; PWM period = 15 steps.
REQ-016 Per LED, priority order: en_i = 0 -> level 0; else pattern_q[i] = 1 -> level 15; else decay_tick and level > 0 -> level - 1; else hold.
REQ-017 Level SHALL saturate at 0; no wrap to 15 on decay.
REQ-018 Load to 15 SHALL win when lit and decay_tick coincide.
REQ-019 led_o[i] SHALL be registered: on = en_i AND (pwm_cnt < level[i]); level 15 always on, level 0 always off.
REQ-020 led_o[i] = on XNOR OUT_POLARITY.
REQ-021 Latency: led_pattern_i change at edge N reaches pattern_q at N, level at N+1, led_o at N+2.
REQ-022 Duty of led_o[i] over one 15-step PWM period SHALL equal level[i]/15 while level is constant.
REQ-023 en_i = 0 SHALL NOT stop the tick counters or pwm_cnt.

Reset
REQ-024 While rst_i = 1, without clock: pattern_q = 0, all level = 0, pwm_cnt = 0, both tick counters = 0, led_o = all off (8'hFF at OUT_POLARITY = 0, 8'h00 at 1).
REQ-025 Reset asserted mid-fade SHALL abandon all state; first edge after release begins from the reset state.

Structure
REQ-026 Shared package lscc_led_pkg SHALL hold: NumLeds = 8, LedLevelMax = 4'd15, PwmSteps = 15, typedef led_level_t (4-bit).
REQ-027 One sub-module, lscc_tick_gen (parameter DIV, outputs 1-cycle tick), SHALL be instantiated twice for pwm_tick and decay_tick.
REQ-028 Per-LED level logic SHALL be a generate loop over NumLeds, not a separate module.

Verification (PWM_DIV = 1, DECAY_CYCLES = 4, IN_POLARITY = OUT_POLARITY = 0 unless stated)
REQ-029 rst_i = 1, no clock -> led_o = 8'hFF immediately; after release with led_pattern_i = 8'hFF, led_o stays 8'hFF.
REQ-030 en_i = 1, led_pattern_i = 8'hF7 held -> from edge N+2, led_o[3] = 0 every cycle, other bits 1.
REQ-031 Release to 8'hFF after REQ-030 -> level[3] steps 15 -> 0, one step per 4 clocks (60 clocks); per 15-cycle PWM window, count of led_o[3] = 0 equals level; then constant 1.
REQ-032 Re-light bit 3 on a cycle coinciding with decay_tick at level 7 -> level[3] = 15 next edge, no decrement.
REQ-033 en_i dropped at level 10 -> level 0 and led_o = 8'hFF within 2 cycles; en_i raised with pattern 8'hFF -> stays 8'hFF.
REQ-034 OUT_POLARITY = 1, IN_POLARITY = 1, led_pattern_i = 8'h01 -> led_o = 8'h01 steady; reset -> led_o = 8'h00.
